// File: rtl/noc_pkg.sv
// Shared field widths, bit positions and packet types for the torus NoC network interface.
package noc_pkg;

  localparam int unsigned LocW     = 4;
  localparam int unsigned TypeW    = 2;
  localparam int unsigned PayloadW = 23;
  localparam int unsigned PktW     = 2 * LocW + TypeW + PayloadW;

  localparam int unsigned DstLsb   = PktW - LocW;
  localparam int unsigned SrcLsb   = DstLsb - LocW;
  localparam int unsigned TypeLsb  = SrcLsb - TypeW;

  typedef enum logic [TypeW-1:0] {
    IFMAP  = 2'd0,
    FILTER = 2'd1,
    PSUM   = 2'd2,
    CTRL   = 2'd3
  } pkt_type_e;

  typedef struct packed {
    logic [LocW-1:0]     dst;
    logic [LocW-1:0]     src;
    pkt_type_e           pkt_type;
    logic [PayloadW-1:0] payload;
  } noc_pkt_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// In-order synchronous FIFO with valid/ready on both sides; extra pointer MSB tells full from empty.
module noc_sync_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, rptr_q;
  logic             full, empty, push, pop;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                     (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  // A full FIFO never takes a push, even if it pops in the same cycle.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wptr_q[AddrW-1:0]] <= in_data;
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_net_if.sv
// Network interface between a local PE/memory block and its router port: packs, steers,
// loops back self-addressed sends, filters misrouted arrivals and counts drops.
module noc_net_if
  import noc_pkg::*;
#(
  parameter int unsigned WIDTH_PACKAGE = 33,
  parameter int unsigned PAYLOAD_W     = 23,
  parameter logic [3:0]  LOCAL_LOC     = 4'b00_00,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [3:0]               tx_dst,
  input  logic [1:0]               tx_type,
  input  logic [PAYLOAD_W-1:0]     tx_payload,
  output logic                     net_out_valid,
  input  logic                     net_out_ready,
  output logic [WIDTH_PACKAGE-1:0] net_out_data,
  input  logic                     net_in_valid,
  output logic                     net_in_ready,
  input  logic [WIDTH_PACKAGE-1:0] net_in_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [3:0]               rx_src,
  output logic [1:0]               rx_type,
  output logic [PAYLOAD_W-1:0]     rx_payload,
  output logic [7:0]               drop_count
);

  localparam int unsigned TypeLo = PAYLOAD_W;
  localparam int unsigned SrcLo  = PAYLOAD_W + TypeW;
  localparam int unsigned DstLo  = SrcLo + LocW;

  logic [WIDTH_PACKAGE-1:0] tx_pkt, rx_in_data, rx_out_data;
  logic                     tx_local, in_local, net_push, loop_push;
  logic                     txf_in_valid, txf_in_ready, rxf_in_valid, rxf_in_ready;
  logic [7:0]               drop_count_q;
  logic                     unused_rx_dst;

  assign tx_pkt   = {tx_dst, LOCAL_LOC, tx_type, tx_payload};
  assign tx_local = (tx_dst == LOCAL_LOC);
  assign in_local = (net_in_data[DstLo +: LocW] == LOCAL_LOC);

  // Misrouted arrivals are always swallowed so a full RX FIFO cannot wedge the router.
  assign net_in_ready = !in_local || rxf_in_ready;
  assign net_push     = net_in_valid && in_local && rxf_in_ready;
  assign loop_push    = tx_valid && tx_local && rxf_in_ready && !net_push;

  assign tx_ready     = tx_local ? (rxf_in_ready && !net_push) : txf_in_ready;
  assign txf_in_valid = tx_valid && !tx_local;
  assign rxf_in_valid = net_push || loop_push;
  assign rx_in_data   = net_push ? net_in_data : tx_pkt;

  noc_sync_fifo #(
    .Width (WIDTH_PACKAGE),
    .Depth (DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (txf_in_valid),
    .in_ready  (txf_in_ready),
    .in_data   (tx_pkt),
    .out_valid (net_out_valid),
    .out_ready (net_out_ready),
    .out_data  (net_out_data)
  );

  noc_sync_fifo #(
    .Width (WIDTH_PACKAGE),
    .Depth (DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rxf_in_valid),
    .in_ready  (rxf_in_ready),
    .in_data   (rx_in_data),
    .out_valid (rx_valid),
    .out_ready (rx_ready),
    .out_data  (rx_out_data)
  );

  assign rx_src        = rx_out_data[SrcLo +: LocW];
  assign rx_type       = rx_out_data[TypeLo +: TypeW];
  assign rx_payload    = rx_out_data[PAYLOAD_W-1:0];
  assign unused_rx_dst = ^rx_out_data[DstLo +: LocW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_q <= '0;
    end else if (net_in_valid && !in_local && (drop_count_q != 8'hFF)) begin
      drop_count_q <= drop_count_q + 8'd1;
    end
  end

  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_noc_net_if.sv
// Directed self-checking bench for noc_net_if with LOCAL_LOC = 4'b01_10.
module tb_noc_net_if;
  import noc_pkg::*;

  localparam logic [3:0] Loc = 4'b01_10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_valid = 1'b0, tx_ready;
  logic [3:0]  tx_dst = '0;
  logic [1:0]  tx_type = '0;
  logic [22:0] tx_payload = '0;
  logic        net_out_valid, net_out_ready = 1'b0;
  logic [32:0] net_out_data;
  logic        net_in_valid = 1'b0, net_in_ready;
  logic [32:0] net_in_data = '0;
  logic        rx_valid, rx_ready = 1'b0;
  logic [3:0]  rx_src;
  logic [1:0]  rx_type;
  logic [22:0] rx_payload;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  noc_net_if #(
    .WIDTH_PACKAGE (33),
    .PAYLOAD_W     (23),
    .LOCAL_LOC     (Loc),
    .DEPTH         (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_dst        (tx_dst),
    .tx_type       (tx_type),
    .tx_payload    (tx_payload),
    .net_out_valid (net_out_valid),
    .net_out_ready (net_out_ready),
    .net_out_data  (net_out_data),
    .net_in_valid  (net_in_valid),
    .net_in_ready  (net_in_ready),
    .net_in_data   (net_in_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_src        (rx_src),
    .rx_type       (rx_type),
    .rx_payload    (rx_payload),
    .drop_count    (drop_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] mk_pkt(input logic [3:0] dst, input logic [3:0] src,
                                         input logic [1:0] typ, input logic [22:0] pl);
    noc_pkt_t p;
    p.dst      = dst;
    p.src      = src;
    p.pkt_type = pkt_type_e'(typ);
    p.payload  = pl;
    return p;
  endfunction

  // Advance one clock edge and return to the falling edge, where inputs change and outputs settle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, net_out_valid, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_drop"}, drop_count, 0);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_in_ready"}, net_in_ready, 1);
    check({tag, "_out_data"}, net_out_data, 0);
    check({tag, "_rx_fields"}, {rx_src, rx_type, rx_payload}, 0);
  endtask

  initial begin
    @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single TX packet encoding and latency.
    tx_valid = 1'b1; tx_dst = 4'b11_00; tx_type = 2'd2; tx_payload = 23'h00ABCD;
    #1 check("tx1_ready", tx_ready, 1);
    check("tx1_not_yet", net_out_valid, 0);
    step();
    tx_valid = 1'b0;
    #1 check("tx1_valid", net_out_valid, 1);
    check("tx1_data", net_out_data, 64'h1_8D00ABCD);
    step();
    check("tx1_held", net_out_data, 64'h1_8D00ABCD);
    net_out_ready = 1'b1;
    step();
    net_out_ready = 1'b0;
    #1 check("tx1_popped", net_out_valid, 0);

    // TX back-pressure: four fit, the fifth waits for the first pop.
    for (int i = 1; i <= 5; i++) begin
      tx_valid = 1'b1; tx_dst = 4'b11_00; tx_type = 2'd0; tx_payload = 23'(i);
      #1 check($sformatf("bp_ready%0d", i), tx_ready, (i <= 4) ? 1 : 0);
      if (i <= 4) step();
    end
    net_out_ready = 1'b1;
    #1 check("bp_ready_indep", tx_ready, 0);
    check("bp_head1", net_out_data[22:0], 1);
    step();
    #1 check("bp_ready_after_pop", tx_ready, 1);
    check("bp_head2", net_out_data[22:0], 2);
    step();
    tx_valid = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      #1 check($sformatf("bp_head%0d", i), net_out_data[22:0], 23'(i));
      check($sformatf("bp_valid%0d", i), net_out_valid, 1);
      step();
    end
    #1 check("bp_drained", net_out_valid, 0);
    net_out_ready = 1'b0;

    // RX fill with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      net_in_valid = 1'b1;
      net_in_data  = mk_pkt(Loc, 4'b00_00, 2'd1, 23'h1000 + 23'(i));
      #1 check($sformatf("rx_in_ready%0d", i), net_in_ready, 1);
      step();
      if (i == 0) begin
        #1 check("rx_latency", rx_valid, 1);
      end
    end
    #1 check("rx_full_ready", net_in_ready, 0);
    check("rx_src", rx_src, 0);
    check("rx_type", rx_type, 1);
    check("rx_payload", rx_payload, 23'h1000);

    // Misrouted arrivals are swallowed even with the RX FIFO full.
    net_in_data = mk_pkt(4'b00_01, 4'b10_10, 2'd3, 23'h7FFFFF);
    #1 check("mis_ready", net_in_ready, 1);
    step();
    #1 check("mis_drop1", drop_count, 1);
    check("mis_rx_valid", rx_valid, 1);
    check("mis_rx_payload", rx_payload, 23'h1000);
    for (int i = 0; i < 299; i++) step();
    #1 check("mis_saturate", drop_count, 255);
    net_in_valid = 1'b0;

    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("rx_order%0d", i), rx_payload, 23'h1000 + 23'(i));
      step();
    end
    #1 check("rx_drained", rx_valid, 0);
    rx_ready = 1'b0;

    // Network arrival beats a simultaneous loopback send.
    tx_valid = 1'b1; tx_dst = Loc; tx_type = 2'd3; tx_payload = 23'h777;
    net_in_valid = 1'b1; net_in_data = mk_pkt(Loc, 4'b11_11, 2'd0, 23'h555);
    #1 check("lb_stall", tx_ready, 0);
    check("lb_in_ready", net_in_ready, 1);
    step();
    net_in_valid = 1'b0;
    #1 check("lb_go", tx_ready, 1);
    check("lb_no_net1", net_out_valid, 0);
    step();
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    #1 check("lb_first", {rx_src, rx_type, rx_payload}, {4'b11_11, 2'd0, 23'h555});
    step();
    #1 check("lb_second", {rx_src, rx_type, rx_payload}, {Loc, 2'd3, 23'h777});
    check("lb_no_net2", net_out_valid, 0);
    step();
    #1 check("lb_drained", rx_valid, 0);
    rx_ready = 1'b0;

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 2; i++) begin
      tx_valid = 1'b1; tx_dst = 4'b00_11; tx_type = 2'd1; tx_payload = 23'h2000 + 23'(i);
      net_in_valid = 1'b1; net_in_data = mk_pkt(Loc, 4'b00_01, 2'd2, 23'h3000 + 23'(i));
      step();
    end
    #1 check("ar_pre_tx", net_out_valid, 1);
    check("ar_pre_rx", rx_valid, 1);
    #2 rst_n = 1'b0;
    tx_valid = 1'b0; net_in_valid = 1'b0; net_in_data = '0;
    #1 check_idle_outputs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    #1 check("ar_post_tx", net_out_valid, 0);
    check("ar_post_rx", rx_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_net_if.md
# noc_net_if

Clocked network interface between a local PE or memory block and its router's PE/memory port in the 4x4 torus NoC. It packs local send requests into 33-bit NoC packets and buffers them toward the router's injection port. It accepts packets ejected by the router, checks their destination and buffers them for the local block. Self-addressed sends are looped back locally and never enter the network.

## Interface
- `WIDTH_PACKAGE`, 33: packet width. Must equal 4 + 4 + 2 + `PAYLOAD_W`.
- `PAYLOAD_W`, 23: payload field width.
- `LOCAL_LOC`, 4'b00_00: this node's location, `{x[1:0], y[1:0]}`.
- `DEPTH`, 4: entries per FIFO. Power of two, ≥2.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_valid` in 1: local send request.
- `tx_ready` out 1: TX can accept.
- `tx_dst` in 4: destination location.
- `tx_type` in 2: packet type.
- `tx_payload` in `PAYLOAD_W`: payload.
- `net_out_valid` out 1: packet toward the router.
- `net_out_ready` in 1: router accepts.
- `net_out_data` out `WIDTH_PACKAGE`: packet toward the router.
- `net_in_valid` in 1: packet from the router.
- `net_in_ready` out 1: RX can accept.
- `net_in_data` in `WIDTH_PACKAGE`: packet from the router.
- `rx_valid` out 1: delivered packet.
- `rx_ready` in 1: local block consumes.
- `rx_src` out 4: source location.
- `rx_type` out 2: packet type.
- `rx_payload` out `PAYLOAD_W`: payload.
- `drop_count` out 8: misrouted packets dropped, saturating.

## Operation
- Packet layout: [32:29] dst, [28:25] src, [24:23] type, [22:0] payload. Encoder sets src = `LOCAL_LOC`.
- TX path: a TX FIFO feeds `net_out_*`. Transfers happen on `valid && ready` at a rising edge.
- `tx_ready` = TX FIFO not full. It is independent of `net_out_ready`, so no combinational path.
- Loopback: a TX request with `tx_dst == LOCAL_LOC` goes to the RX FIFO, not the TX FIFO.
  - In that case `tx_ready` = RX FIFO not full AND no `net_in` push this cycle.
  - A network arrival always wins over loopback; the loopback request stalls.
- RX path: a network packet with dst == `LOCAL_LOC` is pushed to the RX FIFO.
  - `net_in_ready` = RX FIFO not full.
- Misrouted arrival (dst ≠ `LOCAL_LOC`):
  - Accepted even if the RX FIFO is full: `net_in_ready` is forced high when `net_in_data` dst ≠ `LOCAL_LOC`.
  - The packet is discarded and `drop_count` increments, saturating at 255.
- FIFO order is strictly in-order. Simultaneous push and pop are allowed in any fill state except a push into a full FIFO, which is never accepted.
- Reset mid-operation: all FIFO contents are discarded and in-flight transfers are lost.

## Timing
- Reset values:
  - `net_out_valid` = 0, `rx_valid` = 0, `drop_count` = 0.
  - `tx_ready` = 1, `net_in_ready` = 1.
  - Data outputs = 0.
- TX latency: request accepted at edge N → `net_out_valid` = 1 from edge N (registered FIFO head, visible after N). The packet is held stable until the `net_out_ready` handshake.
- RX latency: packet accepted at edge N → `rx_valid` = 1 after N. Loopback has the same one-cycle latency.
- `valid` never deasserts without a handshake. Data is stable while `valid && !ready`.
- Throughput: one packet per cycle per direction when not back-pressured.
- Pointer wrap-around uses an extra MSB pointer bit. Full = MSBs differ and low bits equal; empty = pointers equal.

## Structure
- `noc_pkg` holds:
  - field widths and bit positions;
  - a packed `noc_pkt_t` struct (dst, src, type, payload);
  - the `pkt_type_e` enum: IFMAP = 0, FILTER = 1, PSUM = 2, CTRL = 3.
- One sub-module, `noc_sync_fifo`, parameterised by width and depth with valid/ready on both sides. It is instantiated twice: TX and RX.
- Top level holds the encode/decode logic, loopback steering, RX arbitration and the drop counter.

## Test plan
- Reset with `LOCAL_LOC` = 4'b01_10 → every output at its reset value. Then send dst 4'b11_00, type 2, payload 0x00ABCD → `net_out_data` = 0x1_8D00ABCD, one cycle later.
- `net_out_ready` = 0, 5 sends → `tx_ready` low after 4 accepted. Release → 4 packets delivered in order; the fifth is accepted the cycle after the first pop.
- Network packet dst 4'b01_10, src 4'b00_00 → `rx_src` 0, matching type and payload. With `rx_ready` = 0 the FIFO fills and `net_in_ready` drops after 4.
- Misrouted packet dst 4'b00_01 with the RX FIFO full → accepted anyway, `rx_valid` unchanged, `drop_count` increments. 300 misrouted packets → `drop_count` = 255.
- Loopback send to 4'b01_10 in the same cycle as a valid network arrival → the network packet is enqueued first, loopback on the next cycle. `net_out_valid` stays 0 throughout.
- Assert `rst_n` low mid-burst (asynchronous, between edges) → outputs return to reset values immediately; after release, no old packet appears.
